sprite_blit_ctrl: RTL

Sequencer that copies one sprite from a 4-bit palette-index sprite ROM into the frame buffer at a requested screen position. It walks the sprite raster in order, drives the ROM read address, absorbs the ROM's one-cycle registered read latency, and clips against screen edges. It emits one frame-buffer write per visible pixel. It sits between the game-logic draw requester and the shared frame-buffer write port.

---
 rtl/sprite_blit_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_blit_ctrl.sv
// Sprite blitter: walks a SPR_W x SPR_H ROM sprite, clips it to the screen and issues frame-buffer writes.
// Optional build macro SPRITE_TRANSPARENCY_EN suppresses writes of the TKEY palette index.
module sprite_blit_ctrl #(
    parameter int SPR_W  = 126,
    parameter int SPR_H  = 60,
    parameter int SCR_W  = 640,
    parameter int SCR_H  = 480,
    parameter int ROM_AW = 13,
    parameter int FB_AW  = 19
`ifdef SPRITE_TRANSPARENCY_EN
    ,
    parameter logic [3:0] TKEY = 4'h0
`endif
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic signed [10:0]  pos_x,
    input  logic signed [9:0]   pos_y,
    input  logic                stall,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [3:0]          rom_data,
    output logic                fb_we,
    output logic [FB_AW-1:0]    fb_addr,
    output logic [3:0]          fb_data,
    output logic                busy,
    output logic                done
);

    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SPR_W - 1);
    localparam logic [ROM_AW-1:0] IDX_LAST = ROM_AW'(SPR_W * SPR_H - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state_r;
    logic signed [10:0] pos_x_r;
    logic signed [9:0]  pos_y_r;
    logic [COL_W-1:0]   col_r;
    logic [ROW_W-1:0]   row_r;
    logic [ROM_AW-1:0]  idx_r;
    logic               drain_r;
    logic               s1_valid_r;
    logic [COL_W-1:0]   s1_col_r;
    logic [ROW_W-1:0]   s1_row_r;
    logic [ROM_AW-1:0]  s1_idx_r;
    logic               fb_we_r;
    logic [FB_AW-1:0]   fb_addr_r;
    logic [3:0]         fb_data_r;

    logic               run_s;
    logic               stall_s;
    logic               adv_s;
    logic               issue_s;
    logic [11:0]        x_s;
    logic [10:0]        y_s;
    logic               wr_ok_s;
    logic [FB_AW-1:0]   y_ext_s;
    logic [FB_AW-1:0]   fb_addr_s;

    assign run_s   = (state_r == ST_FETCH) || (state_r == ST_DRAIN);
    assign stall_s = stall & run_s;
    assign adv_s   = run_s & ~stall;
    assign issue_s = (state_r == ST_FETCH);

    // Stage-1 screen coordinates, clip test and linear frame-buffer address
    always_comb begin
        x_s       = {pos_x_r[10], pos_x_r} + {{(12 - COL_W){1'b0}}, s1_col_r};
        y_s       = {pos_y_r[9], pos_y_r} + {{(11 - ROW_W){1'b0}}, s1_row_r};
        wr_ok_s   = ~x_s[11] && (x_s[10:0] < 11'(SCR_W)) &&
                    ~y_s[10] && (y_s[9:0] < 10'(SCR_H));
`ifdef SPRITE_TRANSPARENCY_EN
        if (rom_data == TKEY) begin
            wr_ok_s = 1'b0;
        end else begin
            wr_ok_s = wr_ok_s;
        end
`endif
        // Row stride of 640 built from two shifts: y*512 + y*128
        y_ext_s   = FB_AW'(y_s[9:0]);
        fb_addr_s = (y_ext_s << 4'd9) + (y_ext_s << 4'd7) + FB_AW'(x_s[10:0]);
    end

    // While stalled, re-read the item sitting in the ROM output stage so rom_data is preserved
    always_comb begin
        rom_addr = idx_r;
        if (stall_s) begin
            rom_addr = s1_idx_r;
        end else begin
            rom_addr = idx_r;
        end
    end

    // Sequencer state and stage-0 raster counters
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            pos_x_r <= 11'sd0;
            pos_y_r <= 10'sd0;
            col_r   <= {COL_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
            idx_r   <= {ROM_AW{1'b0}};
            drain_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_FETCH;
                        pos_x_r <= pos_x;
                        pos_y_r <= pos_y;
                        col_r   <= {COL_W{1'b0}};
                        row_r   <= {ROW_W{1'b0}};
                        idx_r   <= {ROM_AW{1'b0}};
                    end
                end
                ST_FETCH: begin
                    if (!stall) begin
                        if (idx_r == IDX_LAST) begin
                            state_r <= ST_DRAIN;
                            drain_r <= 1'b0;
                            col_r   <= {COL_W{1'b0}};
                            row_r   <= {ROW_W{1'b0}};
                            idx_r   <= {ROM_AW{1'b0}};
                        end else if (col_r == COL_LAST) begin
                            col_r <= {COL_W{1'b0}};
                            row_r <= row_r + ROW_W'(1'b1);
                            idx_r <= idx_r + ROM_AW'(1'b1);
                        end else begin
                            col_r <= col_r + COL_W'(1'b1);
                            idx_r <= idx_r + ROM_AW'(1'b1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        if (drain_r) begin
                            state_r <= ST_DONE;
                        end else begin
                            drain_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Pipeline: stage 1 carries the in-flight pixel, output stage registers the write
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_r <= 1'b0;
            s1_col_r   <= {COL_W{1'b0}};
            s1_row_r   <= {ROW_W{1'b0}};
            s1_idx_r   <= {ROM_AW{1'b0}};
            fb_we_r    <= 1'b0;
            fb_addr_r  <= {FB_AW{1'b0}};
            fb_data_r  <= 4'd0;
        end else if (adv_s) begin
            s1_valid_r <= issue_s;
            s1_col_r   <= col_r;
            s1_row_r   <= row_r;
            s1_idx_r   <= idx_r;
            fb_we_r    <= s1_valid_r & wr_ok_s;
            if (s1_valid_r && wr_ok_s) begin
                fb_addr_r <= fb_addr_s;
                fb_data_r <= rom_data;
            end
        end else if (!run_s) begin
            s1_valid_r <= 1'b0;
            fb_we_r    <= 1'b0;
        end
    end

    assign fb_we   = fb_we_r & ~stall_s;
    assign fb_addr = fb_addr_r;
    assign fb_data = fb_data_r;
    assign busy    = (state_r != ST_IDLE);
    assign done    = (state_r == ST_DONE);

endmodule
